// File: rtl/mux_burst_arbiter.sv
// Round-robin burst arbiter for two valid/ready requesters.
// Forwards granted beats through a registered output stage.
module mux_burst_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_A = 2'd1;
    localparam logic [1:0] SERVE_B = 2'd2;

    logic [1:0]       state;
    logic             prio;
    logic [CW-1:0]    beat_cnt;
    logic             serve_a;
    logic             serve_b;
    logic             out_free;
    logic             x_valid;
    logic [WIDTH-1:0] x_data;
    logic             xfer;
    logic             leave;

    assign serve_a  = (state == SERVE_A);
    assign serve_b  = (state == SERVE_B);
    assign busy     = serve_a | serve_b;
    assign out_free = !out_valid || out_ready;
    assign a_ready  = serve_a && out_free;
    assign b_ready  = serve_b && out_free;
    assign x_valid  = serve_a ? a_valid : (serve_b && b_valid);
    assign x_data   = serve_a ? a_data : b_data;
    assign xfer     = busy && x_valid && out_free;
    // A grant ends on a full burst or as soon as its owner drops valid.
    assign leave    = !x_valid || (xfer && beat_cnt == LAST);

    // Grant sequencing, burst counting and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            prio      <= 1'b0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (a_valid && (!b_valid || !prio)) begin
                        state    <= SERVE_A;
                        sel      <= 1'b0;
                        beat_cnt <= '0;
                    end else if (b_valid) begin
                        state    <= SERVE_B;
                        sel      <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                SERVE_A, SERVE_B: begin
                    if (xfer) begin
                        out_data  <= x_data;
                        out_valid <= 1'b1;
                        beat_cnt  <= beat_cnt + CW'(1);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (leave) begin
                        state <= IDLE;
                        prio  <= serve_a;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_burst_arbiter.sv
// Randomized and directed bench for mux_burst_arbiter.
// A grant-level reference model predicts every output each cycle.
module tb_mux_burst_arbiter;

    localparam int W    = 8;
    localparam int MAXB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         a_valid = 1'b0;
    logic [W-1:0] a_data = '0;
    logic         a_ready;
    logic         b_valid = 1'b0;
    logic [W-1:0] b_data = '0;
    logic         b_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         sel;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // reference model: who owns the output, beats used, who is favoured
    int         m_owner;
    int         m_used;
    int         m_fav;
    bit         m_ov;
    logic [7:0] m_od;
    bit         m_sel;

    logic [7:0] a_base;
    logic [7:0] b_base;
    int         a_cnt;
    int         b_cnt;

    mux_burst_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a_valid(a_valid),
        .a_data(a_data),
        .a_ready(a_ready),
        .b_valid(b_valid),
        .b_data(b_data),
        .b_ready(b_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .sel(sel),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; asserts reset between clock edges.
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        a_valid   = 1'($urandom);
        b_valid   = 1'($urandom);
        out_ready = 1'($urandom);
        a_data    = 8'($urandom);
        b_data    = 8'($urandom);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        m_owner = -1;
        m_used  = 0;
        m_fav   = 0;
        m_ov    = 0;
        m_od    = '0;
        m_sel   = 0;
        a_cnt   = 0;
        b_cnt   = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, check predictions, advance the model.
    task automatic step(input bit av, input bit bv, input bit ordy);
        bit free;
        bit v;
        a_valid   = av;
        b_valid   = bv;
        out_ready = ordy;
        a_data    = a_base + 8'(a_cnt);
        b_data    = b_base + 8'(b_cnt);
        #1;
        free = !m_ov || ordy;
        chk("a_ready", a_ready, (m_owner == 0) && free);
        chk("b_ready", b_ready, (m_owner == 1) && free);
        chk("busy", busy, m_owner >= 0);
        chk("sel", sel, m_sel);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        if (m_owner < 0) begin
            if (ordy) m_ov = 0;
            if (av && bv) m_owner = m_fav;
            else if (av) m_owner = 0;
            else if (bv) m_owner = 1;
            if (m_owner >= 0) begin
                m_sel  = (m_owner == 1);
                m_used = 0;
            end
        end else begin
            v = (m_owner == 0) ? av : bv;
            if (v && free) begin
                m_od = (m_owner == 0) ? a_data : b_data;
                m_ov = 1;
                m_used++;
                if (m_owner == 0) a_cnt++;
                else b_cnt++;
            end else if (ordy) begin
                m_ov = 0;
            end
            if (!v || m_used == MAXB) begin
                m_fav   = 1 - m_owner;
                m_owner = -1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        a_base = 8'h00;
        b_base = 8'h00;
        do_reset();

        // lone requester A: bursts of four separated by one idle cycle
        a_base = 8'h11;
        for (int i = 0; i < 14; i++) step(1, 0, 1);

        // both requesting: grants alternate A, B, A
        do_reset();
        a_base = 8'hA0;
        b_base = 8'hB0;
        for (int i = 0; i < 18; i++) step(1, 1, 1);

        // A releases after two beats, B takes over
        do_reset();
        a_base = 8'h01;
        b_base = 8'h40;
        for (int i = 0; i < 12; i++) step(a_cnt < 2, 1, 1);

        // backpressure for three cycles in the middle of a burst
        do_reset();
        a_base = 8'h60;
        for (int i = 0; i < 14; i++) step(1, 0, !(i >= 4 && i < 7));

        // random traffic with an asynchronous reset in the middle
        do_reset();
        a_base = 8'($urandom);
        b_base = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                a_base = 8'($urandom);
                b_base = 8'($urandom);
            end
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_burst_arbiter.md
Name: mux_burst_arbiter

Overview:
- Sequencer/arbiter for the shared 2:1 select datapath.
- Two requesters, A and B, each offer data on a valid/ready handshake. The block grants the shared output to one of them at a time and drives the select line (0 = A, 1 = B).
- It forwards the granted beats through a registered output stage.
- Round-robin between requesters, with each grant capped at MAX_BURST beats so neither side starves.

Parameters:
- WIDTH, 8, data width of a_data, b_data, out_data.
- MAX_BURST, 4, maximum beats forwarded per grant (legal range 1..255).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- a_valid, input, 1, requester A has a beat on a_data.
- a_data, input, WIDTH, requester A data.
- a_ready, output, 1, A beat accepted this cycle when a_valid && a_ready.
- b_valid, input, 1, requester B has a beat on b_data.
- b_data, input, WIDTH, requester B data.
- b_ready, output, 1, B beat accepted this cycle when b_valid && b_ready.
- out_valid, output, 1, out_data holds a beat.
- out_data, output, WIDTH, forwarded beat.
- out_ready, input, 1, downstream accepts the beat when out_valid && out_ready.
- sel, output, 1, current grant: 0 = A, 1 = B (registered).
- busy, output, 1, high while in SERVE_A or SERVE_B.

Behaviour:
- Reset (rst_n low, asynchronous, at any time, including mid-burst):
  - state = IDLE, sel = 0, prio = 0 (A favoured), beat_cnt = 0.
  - out_valid = 0, out_data = 0, a_ready = b_ready = 0, busy = 0.
  - Any in-flight beat is discarded.
- States:
  - IDLE, SERVE_A, SERVE_B.
  - sel = 0 in SERVE_A, 1 in SERVE_B. sel holds its last value in IDLE.
- IDLE:
  - a_ready = b_ready = 0.
  - Both valid: go to SERVE_A if prio = 0, else SERVE_B.
  - Only one valid: go to that requester's SERVE state.
  - Neither valid: stay in IDLE.
  - On any SERVE entry, beat_cnt <= 0 and sel is updated in the same edge.
- SERVE_X:
  - x_ready = !out_valid || out_ready (combinational). The other requester's ready = 0.
  - Transfer when x_valid && x_ready: out_data <= x_data, out_valid <= 1, beat_cnt <= beat_cnt + 1.
  - Otherwise, if out_ready: out_valid <= 0.
  - out_valid/out_data are held stable while out_valid && !out_ready.
- Exit SERVE_X to IDLE on either condition:
  - a transfer with beat_cnt == MAX_BURST-1 (burst complete), or
  - a cycle with x_valid == 0 (requester released).
  - On exit, prio <= the other requester.
  - A stall (x_valid = 1, x_ready = 0) does not exit and does not count.
- Output drain: out_valid may remain 1 into IDLE until out_ready. Forwarded data order equals acceptance order.
- Latency:
  - Request in IDLE at edge N: grant (sel, busy) visible after edge N+1; x_ready high in that cycle if the output is free.
  - First beat appears on out_data after the following edge.
  - Minimum 1 bubble (IDLE) cycle between consecutive grants.
- Throughput: 1 beat/cycle within a burst while out_ready is held high.
- Simultaneous requests alternate A, B, A, B… per grant. A lone requester is re-granted after each IDLE bubble.
- beat_cnt width = clog2(MAX_BURST)+1; beat_cnt never wraps.

Test Plan:
- Reset: rst_n = 0 with random inputs -> out_valid = 0, out_data = 0, sel = 0, busy = 0, a_ready = b_ready = 0. Repeat asynchronously mid-burst -> same values immediately, with no clock edge required.
- A only: a_valid held with data 0x11,0x12,…, out_ready = 1, MAX_BURST = 4 ->
  - out_data 0x11..0x14 on consecutive cycles;
  - then 1 IDLE cycle with a_ready = 0;
  - then 0x15.. resumes;
  - sel = 0 throughout.
- Both valid continuously: A sends 0xA0.., B sends 0xB0.. -> output 0xA0–0xA3, bubble, 0xB0–0xB3, bubble, 0xA4–0xA7. sel toggles per grant.
- Early release: A valid for 2 beats (0x01, 0x02), then a_valid = 0, with B valid -> after 0x01, 0x02 the block goes to IDLE, then to SERVE_B, and B's beats follow. beat_cnt restarts at 0.
- Backpressure: out_ready = 0 for 3 cycles mid-burst -> out_data stable, x_ready = 0, no beats lost or duplicated, burst count unaffected. After release the remaining beats complete the 4-beat burst.
- Priority after reset: a_valid and b_valid rise in the same cycle -> A granted first (sel = 0), then B next.
